// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - pixel plot / frame clear writer for a 160x120 3-bit framebuffer
module framebuffer_writer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DEPTH  = WIDTH * HEIGHT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        plot,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_col,
  output logic        ready,
  input  logic        clear,
  input  logic [2:0]  clear_col,
  output logic        busy,
  output logic        done,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic [7:0]  drop_count
);

  localparam logic [7:0]  X_LIM     = 8'(WIDTH);
  localparam logic [6:0]  Y_LIM     = 7'(HEIGHT);
  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [2:0]  col_q, col_d;
  logic        wr_en_q, wr_en_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [2:0]  wr_data_q, wr_data_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [7:0]  drop_q, drop_d;

  logic        in_range;
  logic [14:0] y_ext;
  logic [14:0] pix_addr;

  assign ready    = (state_q == IDLE) && !clear && !reset;
  assign busy     = (state_q == CLEAR);
  assign done     = done_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign drop_count = drop_q;

  // y*160 + x built from shifts: y*128 + y*32 + x
  assign in_range = (in_x < X_LIM) && (in_y < Y_LIM);
  assign y_ext    = {8'd0, in_y};
  assign pix_addr = (y_ext << 7) + (y_ext << 5) + {7'd0, in_x};

  // Next-state and write-port selection; pixel writes only from IDLE, fill writes only from CLEAR
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    last_d    = 1'b0;
    done_d    = last_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = 15'd0;
          col_d   = clear_col;
        end else if (plot && ready) begin
          if (in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_addr;
            wr_data_d = in_col;
          end else if (drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = col_q;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = 15'd0;
          last_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 15'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight write immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 15'd0;
      col_q     <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 15'd0;
      wr_data_q <= 3'd0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - randomized self-checking bench for framebuffer_writer
module tb_framebuffer_writer;

  localparam int W = 160;
  localparam int H = 120;
  localparam int D = W * H;

  logic        clock = 1'b0;
  logic        reset;
  logic        plot;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_col;
  logic        ready;
  logic        clear;
  logic [2:0]  clear_col;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic [7:0]  drop_count;

  framebuffer_writer dut (
    .clock      (clock),
    .reset      (reset),
    .plot       (plot),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_col     (in_col),
    .ready      (ready),
    .clear      (clear),
    .clear_col  (clear_col),
    .busy       (busy),
    .done       (done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  // Reference model: edge index n, fill start edge s (-1 = none)
  int n = 0;
  int s = -1;
  int m_wr_en = 0;
  int m_addr = 0;
  int m_data = 0;
  int m_done = 0;
  int m_drop = 0;
  int m_col = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit fill_busy_after(input int edge_idx);
    return (s >= 0) && (edge_idx >= s) && (edge_idx < s + D);
  endfunction

  // Model update at each edge: fill writes occupy edges s+1..s+D, done at s+D+1
  always @(posedge clock) begin
    n++;
    if (reset) begin
      s = -1;
      m_wr_en = 0;
      m_addr = 0;
      m_data = 0;
      m_done = 0;
      m_drop = 0;
    end else begin
      bit prev_busy;
      prev_busy = fill_busy_after(n - 1);
      m_wr_en = 0;
      m_done = (s >= 0 && n == s + D + 1) ? 1 : 0;
      if (s >= 0 && n >= s + 1 && n <= s + D) begin
        m_wr_en = 1;
        m_addr = n - s - 1;
        m_data = m_col;
      end
      if (plot && !prev_busy && !clear) begin
        if (in_x < W && in_y < H) begin
          m_wr_en = 1;
          m_addr = in_y * W + in_x;
          m_data = in_col;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      if (clear && !prev_busy) begin
        s = n;
        m_col = clear_col;
      end
    end
  end

  task automatic tick();
    bit exp_busy;
    @(negedge clock);
    exp_busy = fill_busy_after(n);
    check_val("wr_en", wr_en, m_wr_en);
    check_val("wr_addr", wr_addr, m_addr);
    check_val("wr_data", wr_data, m_data);
    check_val("done", done, m_done);
    check_val("busy", busy, exp_busy);
    check_val("drop_count", drop_count, m_drop);
    check_val("ready", ready, (!exp_busy && !clear && !reset));
    if (done === 1'b1) done_pulses++;
  endtask

  task automatic set_pix(input bit p, input int x, input int y, input int c);
    plot = p;
    in_x = 8'(x);
    in_y = 7'(y);
    in_col = 3'(c);
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    clear_col = 3'd0;
    set_pix(0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single pixel at origin, then idle
    set_pix(1, 0, 0, 5);
    tick();
    check_val("origin_addr", wr_addr, 0);
    check_val("origin_data", wr_data, 5);
    set_pix(0, 0, 0, 0);
    tick();
    check_val("origin_wr_en_off", wr_en, 0);

    // Back-to-back corner and (1,1)
    set_pix(1, 159, 119, 3);
    tick();
    check_val("corner_addr", wr_addr, 19199);
    set_pix(1, 1, 1, 7);
    tick();
    check_val("pix11_addr", wr_addr, 161);
    set_pix(0, 0, 0, 0);
    tick();

    // Out-of-range boundaries
    set_pix(1, 160, 0, 1);
    tick();
    set_pix(1, 0, 120, 1);
    tick();
    set_pix(0, 0, 0, 0);
    tick();
    check_val("drop_two", drop_count, 2);
    for (int i = 0; i < 300; i++) begin
      set_pix(1, $urandom_range(160, 255), $urandom_range(0, 127), $urandom_range(0, 7));
      tick();
    end
    set_pix(0, 0, 0, 0);
    tick();
    check_val("drop_sat", drop_count, 255);

    // Reset clears drop count, then random pixel traffic
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      set_pix(($urandom_range(0, 3) != 0), $urandom_range(0, 170), $urandom_range(0, 127),
              $urandom_range(0, 7));
      tick();
    end
    set_pix(0, 0, 0, 0);
    tick();

    // Full clear with colour 2, random plot attempts during the fill
    done_pulses = 0;
    clear = 1'b1;
    clear_col = 3'd2;
    tick();
    clear = 1'b0;
    clear_col = 3'd5;
    for (int i = 0; i < D + 4; i++) begin
      set_pix($urandom_range(0, 1), $urandom_range(0, 159), $urandom_range(0, 119),
              $urandom_range(0, 7));
      tick();
      if (i == D + 1) check_val("fill_done_after_19201", done_pulses, 1);
      if (i >= D + 1) set_pix(0, 0, 0, 0);
    end
    check_val("fill1_done_once", done_pulses, 1);

    // Clear and plot together: clear wins; re-clear at fill cycle 100 ignored
    done_pulses = 0;
    clear = 1'b1;
    clear_col = 3'd6;
    set_pix(1, 3, 3, 1);
    tick();
    clear = 1'b0;
    for (int i = 0; i < D + 6; i++) begin
      if (i == 100) clear = 1'b1;
      if (i == 101) clear = 1'b0;
      if (i == 4) set_pix(0, 0, 0, 0);
      tick();
    end
    check_val("fill2_done_once", done_pulses, 1);

    // Reset mid-fill at address 5000, then restart from address 0
    clear = 1'b1;
    clear_col = 3'd4;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (wr_en === 1'b1 && wr_addr == 15'd5000) break;
      tick();
    end
    check_val("reach_addr_5000", wr_addr, 5000);
    reset = 1'b1;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_wr_en", wr_en, 0);
    check_val("rst_wr_addr", wr_addr, 0);
    tick();
    reset = 1'b0;
    tick();
    clear = 1'b1;
    clear_col = 3'd1;
    tick();
    clear = 1'b0;
    tick();
    check_val("restart_addr0", wr_addr, 0);
    check_val("restart_en", wr_en, 1);
    for (int i = 0; i < 20; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
